// File: rtl/keypad_scanner_pkg.sv
// Shared types and key codes for the matrix keypad scanner.
// Key codes match the encoding control_unit expects on its button input.
package keypad_scanner_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0] KEY_ADD   = 4'hA;
  localparam logic [3:0] KEY_SUB   = 4'hB;
  localparam logic [3:0] KEY_MUL   = 4'hC;
  localparam logic [3:0] KEY_DIV   = 4'hD;
  localparam logic [3:0] KEY_EQUAL = 4'hE;
  localparam logic [3:0] KEY_CLEAR = 4'hF;

  // Exactly one column pulled low; all-high or multi-key patterns are "none".
  function automatic logic col_valid(input logic [3:0] c);
    logic [3:0] n;
    n = ~c;
    return (n != 4'd0) && ((n & (n - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/keypad_scanner_sync_2ff.sv
// Two-flop synchronizer for the asynchronous keypad columns.
// Resets to all-ones so an idle (pulled-high) keypad reads as "none".
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_q, sync_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q <= '1;
      sync_q <= '1;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: row scan, press/release debounce, key encoding and a
// single-cycle is_pressed_next strobe per physical press.
module keypad_scanner
  import keypad_scanner_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_COUNT = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] button,
  output logic       is_pressed_next,
  output logic       key_down
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_COUNT + 1);

  logic [3:0]    col_s;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
  kp_state_e     state_q, state_d;
  logic [3:0]    row_q, row_d, row_rot;
  logic [3:0]    cand_q, cand_d;
  logic [3:0]    button_q, button_d;
  logic          strobe_q, strobe_d;
  logic          key_down_q, key_down_d;
  logic          sample, valid;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (col),
    .q     (col_s)
  );

  function automatic logic [3:0] key_code(input logic [3:0] r, input logic [3:0] c);
    logic [3:0] code;
    case ({r, c})
      8'b1110_1110: code = 4'h1;
      8'b1110_1101: code = 4'h2;
      8'b1110_1011: code = 4'h3;
      8'b1110_0111: code = KEY_ADD;
      8'b1101_1110: code = 4'h4;
      8'b1101_1101: code = 4'h5;
      8'b1101_1011: code = 4'h6;
      8'b1101_0111: code = KEY_SUB;
      8'b1011_1110: code = 4'h7;
      8'b1011_1101: code = 4'h8;
      8'b1011_1011: code = 4'h9;
      8'b1011_0111: code = KEY_MUL;
      8'b0111_1110: code = KEY_CLEAR;
      8'b0111_1101: code = 4'h0;
      8'b0111_1011: code = KEY_EQUAL;
      8'b0111_0111: code = KEY_DIV;
      default:      code = 4'h0;
    endcase
    return code;
  endfunction

  assign sample  = (dwell_q == DW'(SCAN_DIV - 1));
  assign valid   = col_valid(col_s);
  assign cnt_inc = cnt_q + CW'(1);
  assign row_rot = {row_q[2:0], row_q[3]};

  always_comb begin
    dwell_d    = sample ? '0 : dwell_q + DW'(1);
    cnt_d      = cnt_q;
    state_d    = state_q;
    row_d      = row_q;
    cand_d     = cand_q;
    button_d   = button_q;
    strobe_d   = 1'b0;
    key_down_d = key_down_q;
    if (sample) begin
      unique case (state_q)
        SCAN: begin
          if (valid) begin
            cand_d  = col_s;
            cnt_d   = CW'(1);
            state_d = DEBOUNCE;
          end else begin
            row_d = row_rot;
          end
        end
        DEBOUNCE: begin
          if (valid && col_s == cand_q) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_COUNT)) begin
              button_d   = key_code(row_q, col_s);
              strobe_d   = 1'b1;
              key_down_d = 1'b1;
              state_d    = HELD;
            end
          end else begin
            state_d = SCAN;
            row_d   = row_rot;
          end
        end
        HELD: begin
          // Any key pattern keeps the hold: no auto-repeat, no rollover.
          if (!valid) begin
            cnt_d   = CW'(1);
            state_d = RELEASE;
          end
        end
        RELEASE: begin
          if (!valid) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CW'(DEBOUNCE_COUNT)) begin
              key_down_d = 1'b0;
              state_d    = SCAN;
              row_d      = row_rot;
            end
          end else begin
            state_d = HELD;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      dwell_q    <= '0;
      cnt_q      <= '0;
      state_q    <= SCAN;
      row_q      <= 4'b1110;
      cand_q     <= 4'hF;
      button_q   <= 4'h0;
      strobe_q   <= 1'b0;
      key_down_q <= 1'b0;
    end else begin
      dwell_q    <= dwell_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      row_q      <= row_d;
      cand_q     <= cand_d;
      button_q   <= button_d;
      strobe_q   <= strobe_d;
      key_down_q <= key_down_d;
    end
  end

  assign row             = row_q;
  assign button          = button_q;
  assign is_pressed_next = strobe_q;
  assign key_down        = key_down_q;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Drives a 4x4 matrix keypad and produces the `button` / `is_pressed_next` pair consumed by `control_unit`.
- Scans rows, debounces presses and releases, and encodes each key into the calculator's 4-bit key code.
- Emits exactly one single-cycle `is_pressed_next` strobe per physical key press.
- Sits between the board keypad pins and `control_unit`.

Parameters:
- SCAN_DIV, 1000: clock cycles each row is driven per sample (dwell); must be >= 4.
- DEBOUNCE_COUNT, 4: consecutive identical samples required to accept a press or a release; must be >= 2.

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous reset
- col  input  4  keypad columns, active-low, externally pulled high, asynchronous to clock
- row  output  4  keypad row drive, active-low; exactly one bit low at all times
- button  output  4  key code of last accepted press; connects to `control_unit.button`
- is_pressed_next  output  1  one-cycle strobe; `button` is valid in the same cycle
- key_down  output  1  level, high from accept until release is debounced

Behaviour:
- Clocking and reset:
  - One clock domain; reset is synchronous and active-high, sampled on the rising edge of `clock`.
  - Reset values: row=4'b1110, button=4'h0, is_pressed_next=0, key_down=0, state=SCAN, dwell and debounce counters 0, synchronizer flops 4'hF.
- Column synchronization: `col` passes through a 2-flop synchronizer; all decisions use the synchronized value `col_s`.
- Dwell and sampling:
  - A dwell counter runs 0..SCAN_DIV-1 and wraps.
  - `col_s` is sampled only when dwell==SCAN_DIV-1 (the "sample cycle").
  - Row changes, where allowed, take effect the cycle after a sample cycle.
- Valid sample:
  - Exactly one bit of `col_s` is low.
  - All-high means "none".
  - Two or more low bits is invalid and is treated as "none".
- SCAN state:
  - At each sample, rotate `row` (1110 -> 1101 -> 1011 -> 0111 -> 1110).
  - On a valid sample: hold the row, latch candidate (r,c), set cnt=1, go to DEBOUNCE.
- DEBOUNCE state:
  - Each sample that matches the candidate increments cnt.
  - On a mismatch (including "none"): go to SCAN and rotate as if no key had been seen; no strobe.
  - When cnt reaches DEBOUNCE_COUNT: in the next cycle, register button=code(r,c) and assert is_pressed_next=1 and key_down=1, then go to HELD.
  - is_pressed_next deasserts the following cycle.
- HELD state:
  - Row stays locked.
  - A "none" sample sets cnt=1 and goes to RELEASE.
  - Any other sample, including a different column, keeps HELD and produces no new strobe (no auto-repeat, no rollover).
- RELEASE state:
  - Each "none" sample increments cnt; at DEBOUNCE_COUNT, clear key_down and go to SCAN, resuming from the next row.
  - Any key sample returns to HELD; no strobe.
- Other rules:
  - `button` holds its value between strobes and never changes outside a strobe cycle.
  - Reset asserted mid-debounce or mid-hold aborts with no strobe; all outputs return to reset values the next cycle.
- Press latency: from the first sample cycle that sees the key, the strobe comes (DEBOUNCE_COUNT-1)*SCAN_DIV+1 cycles later. Add 2 cycles of synchronizer delay from the pin.
- Key map, row r / col c (decided, shared with control_unit):
  - r0: 1, 2, 3, add
  - r1: 4, 5, 6, sub
  - r2: 7, 8, 9, mul
  - r3: clear, 0, equal, div
- Key codes: digits 0-9 = 4'h0-4'h9; add=4'hA, sub=4'hB, mul=4'hC, div=4'hD, equal=4'hE, clear=4'hF.

Decomposition:
- Shared defines header (calculator_defines.vh), already included by `control_unit`:
  - Key-code macros `add, `sub, `mul, `div, `equal, `clear.
  - Keypad state encodings (SCAN, DEBOUNCE, HELD, RELEASE).
- One sub-module, `sync_2ff` (parameterized width, reset value all-ones), for the column synchronizer.
- The key map is a case statement inside keypad_scanner.

Test Plan (SCAN_DIV=4, DEBOUNCE_COUNT=3, bench models the matrix: col[c]=0 when the key is held and row[r]=0):
- Reset: assert reset for 2 cycles -> row=4'b1110, button=4'h0, is_pressed_next=0, key_down=0. Release -> row walks 1110, 1101, 1011, 0111, 1110 every 4 cycles.
- Hold key r2/c1 ("8") steadily -> exactly one is_pressed_next pulse with button=4'h8 in that cycle; key_down=1; row frozen at 4'b1011; no further pulses while held.
- Release "8" for >= 12 cycles -> key_down falls after 3 all-high samples; scanning resumes at row 4'b0111.
- Bounce: press r3/c3 ("div") for one sample, release for one, then hold -> no pulse during the bounce; one pulse with button=4'hD after 3 stable samples.
- Release bounce: while "div" is held, drop it for 2 samples and restore -> key_down stays 1, no new pulse.
- Reset during DEBOUNCE of r0/c3 ("add") -> no pulse; button stays 4'h0.
- Sequence "3", "add", "2", "equal" -> four pulses, button = 4'h3, 4'hA, 4'h2, 4'hE. Feed these into `control_unit`; it must show a displayed result of 5.
